// File: rtl/axis_arb_pkg.sv
// Shared constants, FSM state type and round-robin pick function for the
// 3-to-1 AXI-Stream arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
package axis_arb_pkg;

    localparam int NUM_PORTS = 3;
    localparam int GRANT_W   = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Winner is the first valid source searching last+1, last+2, last (mod 3).
    // With nothing valid the previous grant is returned unchanged.
    function automatic logic [GRANT_W-1:0] rr_pick(
        input logic [NUM_PORTS-1:0] valid,
        input logic [GRANT_W-1:0]   last_grant
    );
        logic [GRANT_W-1:0] p1;
        logic [GRANT_W-1:0] p2;
        p1 = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
        if (valid[p1])
            rr_pick = p1;
        else if (valid[p2])
            rr_pick = p2;
        else
            rr_pick = last_grant;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register (data/keep/last[/tid] + valid).
// Latency: 1 cycle from load to m_axis_tvalid.
// Backpressure: in_rdy = !valid | m_axis_tready; contents held stable while stalled.
// Ports: load/in_* from the arbiter mux, in_rdy back to it, m_axis_* to the sink.
// Optional: AXIS_ARB_TID_EN adds in_tid / m_axis_tid (source index per beat).
module axis_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic                  in_last,
`ifdef AXIS_ARB_TID_EN
    input  logic [1:0]            in_tid,
    output logic [1:0]            m_axis_tid,
`endif
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    // Empty, or the held beat leaves this cycle: either way a new beat fits.
    assign in_rdy = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
`ifdef AXIS_ARB_TID_EN
            m_axis_tid    <= 2'd0;
`endif
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= in_data;
            m_axis_tkeep  <= in_keep;
            m_axis_tlast  <= in_last;
`ifdef AXIS_ARB_TID_EN
            m_axis_tid    <= in_tid;
`endif
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin merge of three AXI-Stream sources onto one registered sink.
// Latency: 2 cycles from s_tvalid (idle) to m_tvalid; 1 idle cycle between packets.
// Backpressure: only the granted source sees tready = !m_tvalid | m_tready.
// Ports: s_axis_*_{0,1,2} sources, m_axis_* sink, busy (packet in flight),
// grant (current/last granted source, doubles as RR pointer).
// Optional: AXIS_ARB_TID_EN adds m_axis_tid carrying the source index of each beat.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
    input  logic                  s_axis_tvalid_0,
    output logic                  s_axis_tready_0,
    input  logic                  s_axis_tlast_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
`ifdef AXIS_ARB_TID_EN
    output logic [1:0]            m_axis_tid,
`endif
    output logic                  busy,
    output logic [1:0]            grant
);

    arb_state_t              state;
    logic [GRANT_W-1:0]      grant_q;
    logic [NUM_PORTS-1:0]    src_vld;
    logic                    out_rdy;
    logic                    sel_vld;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [KEEP_WIDTH-1:0]   sel_keep;
    logic                    sel_rdy;
    logic                    xfer;

    assign src_vld = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};

    // Input mux follows the registered grant; it is only consumed in BUSY.
    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        sel_keep = '0;
        case (grant_q)
            2'd0: begin
                sel_vld  = s_axis_tvalid_0;
                sel_last = s_axis_tlast_0;
                sel_data = s_axis_tdata_0;
                sel_keep = s_axis_tkeep_0;
            end
            2'd1: begin
                sel_vld  = s_axis_tvalid_1;
                sel_last = s_axis_tlast_1;
                sel_data = s_axis_tdata_1;
                sel_keep = s_axis_tkeep_1;
            end
            2'd2: begin
                sel_vld  = s_axis_tvalid_2;
                sel_last = s_axis_tlast_2;
                sel_data = s_axis_tdata_2;
                sel_keep = s_axis_tkeep_2;
            end
            default: ;
        endcase
    end

    assign sel_rdy = (state == ARB_BUSY) && out_rdy;
    assign xfer    = sel_rdy && sel_vld;

    assign s_axis_tready_0 = sel_rdy && (grant_q == 2'd0);
    assign s_axis_tready_1 = sel_rdy && (grant_q == 2'd1);
    assign s_axis_tready_2 = sel_rdy && (grant_q == 2'd2);

    assign busy  = (state == ARB_BUSY);
    assign grant = grant_q;

    // Reset pointer 2 gives source 0 first priority. The grant is held through
    // the whole packet, including gaps in tvalid; only an accepted tlast releases it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            grant_q <= 2'd2;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|src_vld) begin
                        state   <= ARB_BUSY;
                        grant_q <= rr_pick(src_vld, grant_q);
                    end
                end
                ARB_BUSY: begin
                    if (xfer && sel_last)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (xfer),
        .in_data       (sel_data),
        .in_keep       (sel_keep),
        .in_last       (sel_last),
`ifdef AXIS_ARB_TID_EN
        .in_tid        (grant_q),
        .m_axis_tid    (m_axis_tid),
`endif
        .in_rdy        (out_rdy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, single packet, fairness,
// backpressure, mid-packet gap, reset mid-packet (tid checked when AXIS_ARB_TID_EN).
module tb_axis_rr_arbiter;

    typedef logic [36:0] beat_t;   // {last, keep, data}
    typedef logic [38:0] obeat_t;  // {tid, last, keep, data}

`ifdef AXIS_ARB_TID_EN
    localparam bit TID_ON = 1'b1;
`else
    localparam bit TID_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2;
    logic [3:0]  s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2;
    logic        s_axis_tvalid_0, s_axis_tvalid_1, s_axis_tvalid_2;
    logic        s_axis_tready_0, s_axis_tready_1, s_axis_tready_2;
    logic        s_axis_tlast_0, s_axis_tlast_1, s_axis_tlast_2;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic [1:0]  grant;
    logic [1:0]  tid_obs;
`ifdef AXIS_ARB_TID_EN
    logic [1:0]  m_axis_tid;
    assign tid_obs = m_axis_tid;
`else
    assign tid_obs = 2'd0;
`endif

    axis_rr_arbiter #(.DATA_WIDTH(32), .KEEP_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata_0(s_axis_tdata_0), .s_axis_tkeep_0(s_axis_tkeep_0),
        .s_axis_tvalid_0(s_axis_tvalid_0), .s_axis_tready_0(s_axis_tready_0),
        .s_axis_tlast_0(s_axis_tlast_0),
        .s_axis_tdata_1(s_axis_tdata_1), .s_axis_tkeep_1(s_axis_tkeep_1),
        .s_axis_tvalid_1(s_axis_tvalid_1), .s_axis_tready_1(s_axis_tready_1),
        .s_axis_tlast_1(s_axis_tlast_1),
        .s_axis_tdata_2(s_axis_tdata_2), .s_axis_tkeep_2(s_axis_tkeep_2),
        .s_axis_tvalid_2(s_axis_tvalid_2), .s_axis_tready_2(s_axis_tready_2),
        .s_axis_tlast_2(s_axis_tlast_2),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
`ifdef AXIS_ARB_TID_EN
        .m_axis_tid(m_axis_tid),
`endif
        .busy(busy), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    beat_t  q0[$], q1[$], q2[$];
    obeat_t outq[$];
    obeat_t expq[$];
    logic [2:0] gate;

    function automatic beat_t mkb(int s, int p, int b, bit last);
        logic [31:0] d;
        d = 32'hA000_0000 | (32'(s) << 8) | (32'(p) << 4) | 32'(b);
        return {last, (last ? 4'h3 : 4'hF), d};
    endfunction

    function automatic obeat_t mko(int s, int p, int b, bit last);
        logic [1:0] t;
        t = TID_ON ? 2'(s) : 2'd0;
        return {t, mkb(s, p, b, last)};
    endfunction

    task automatic drive();
        if (gate[0] && q0.size() > 0) begin
            s_axis_tvalid_0 = 1'b1;
            {s_axis_tlast_0, s_axis_tkeep_0, s_axis_tdata_0} = q0[0];
        end else begin
            s_axis_tvalid_0 = 1'b0;
            {s_axis_tlast_0, s_axis_tkeep_0, s_axis_tdata_0} = '0;
        end
        if (gate[1] && q1.size() > 0) begin
            s_axis_tvalid_1 = 1'b1;
            {s_axis_tlast_1, s_axis_tkeep_1, s_axis_tdata_1} = q1[0];
        end else begin
            s_axis_tvalid_1 = 1'b0;
            {s_axis_tlast_1, s_axis_tkeep_1, s_axis_tdata_1} = '0;
        end
        if (gate[2] && q2.size() > 0) begin
            s_axis_tvalid_2 = 1'b1;
            {s_axis_tlast_2, s_axis_tkeep_2, s_axis_tdata_2} = q2[0];
        end else begin
            s_axis_tvalid_2 = 1'b0;
            {s_axis_tlast_2, s_axis_tkeep_2, s_axis_tdata_2} = '0;
        end
    endtask

    // Called at a falling edge: samples handshakes, crosses one rising edge,
    // retires accepted source beats, re-drives at the next falling edge.
    task automatic step();
        logic f0, f1, f2;
        #1;
        f0 = s_axis_tvalid_0 && s_axis_tready_0;
        f1 = s_axis_tvalid_1 && s_axis_tready_1;
        f2 = s_axis_tvalid_2 && s_axis_tready_2;
        if (m_axis_tvalid && m_axis_tready)
            outq.push_back({tid_obs, m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        @(posedge clk);
        if (f0) void'(q0.pop_front());
        if (f1) void'(q1.pop_front());
        if (f2) void'(q2.pop_front());
        @(negedge clk);
        drive();
    endtask

    function automatic bit is_idle();
        return q0.size() == 0 && q1.size() == 0 && q2.size() == 0 &&
               !m_axis_tvalid && !busy;
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!is_idle() && n < budget) begin
            step();
            n++;
        end
        total++;
        if (!is_idle()) begin
            bad++;
            $display("FAIL %s timeout: idle=%0b after %0d cycles, required 1", name, is_idle(), n);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); outq.delete(); expq.delete();
        gate = 3'b111;
        m_axis_tready = 1'b1;
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive();
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", m_axis_tvalid); end
        total++; if (m_axis_tdata !== 32'h0) begin bad++; $display("FAIL rst_tdata got=%h want=0", m_axis_tdata); end
        total++; if (m_axis_tkeep !== 4'h0 || m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_keep_last got=%h/%b want=0/0", m_axis_tkeep, m_axis_tlast); end
        total++; if (grant !== 2'd2) begin bad++; $display("FAIL rst_grant got=%0d want=2", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if ({s_axis_tready_2, s_axis_tready_1, s_axis_tready_0} !== 3'b000) begin bad++;
            $display("FAIL rst_tready got=%b want=000", {s_axis_tready_2, s_axis_tready_1, s_axis_tready_0}); end
        total++; if (tid_obs !== 2'd0) begin bad++; $display("FAIL rst_tid got=%0d want=0", tid_obs); end
    endtask

    task automatic test_single();
        outq.delete(); expq.delete();
        for (int b = 0; b < 3; b++) begin
            q1.push_back(mkb(1, 0, b, b == 2));
            expq.push_back(mko(1, 0, b, b == 2));
        end
        drive();
        step();  // arbitration bubble
        total++; if (busy !== 1'b1 || grant !== 2'd1 || m_axis_tvalid !== 1'b0) begin bad++;
            $display("FAIL single_arb busy/grant/tvalid got=%b/%0d/%b want=1/1/0", busy, grant, m_axis_tvalid); end
        step();
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA000_0100) begin bad++;
            $display("FAIL single_lat2 tvalid/tdata got=%b/%h want=1/a0000100", m_axis_tvalid, m_axis_tdata); end
        step();
        total++; if (m_axis_tdata !== 32'hA000_0101) begin bad++; $display("FAIL single_b2 got=%h want=a0000101", m_axis_tdata); end
        step();
        total++; if (m_axis_tdata !== 32'hA000_0102 || m_axis_tlast !== 1'b1 || m_axis_tkeep !== 4'h3) begin bad++;
            $display("FAIL single_b3 data/last/keep got=%h/%b/%h want=a0000102/1/3", m_axis_tdata, m_axis_tlast, m_axis_tkeep); end
        total++; if (busy !== 1'b0 || grant !== 2'd1) begin bad++;
            $display("FAIL single_idle busy/grant got=%b/%0d want=0/1", busy, grant); end
        run_until_idle("single", 20);
        total++; if (outq.size() != expq.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin bad++; $display("FAIL single_beat%0d got=%h want=%h", i, outq[i], expq[i]); end
        end
    endtask

    task automatic test_fairness();
        reset_dut();
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 2; b++) begin
                q0.push_back(mkb(0, p, b, b == 1));
                q1.push_back(mkb(1, p, b, b == 1));
                q2.push_back(mkb(2, p, b, b == 1));
            end
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 3; s++)
                for (int b = 0; b < 2; b++)
                    expq.push_back(mko(s, p, b, b == 1));
        drive();
        run_until_idle("fair", 100);
        total++; if (outq.size() != expq.size()) begin bad++; $display("FAIL fair_count got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin bad++; $display("FAIL fair_beat%0d got=%h want=%h", i, outq[i], expq[i]); end
        end
    endtask

    task automatic test_backpressure();
        outq.delete(); expq.delete();
        m_axis_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            q2.push_back(mkb(2, 3, b, b == 3));
            expq.push_back(mko(2, 3, b, b == 3));
        end
        drive();
        step();  // grant
        step();  // beat 0 in register
        step();  // beat 0 out, beat 1 in register
        total++; if (m_axis_tdata !== 32'hA000_0231) begin bad++; $display("FAIL bp_pre got=%h want=a0000231", m_axis_tdata); end
        for (int c = 0; c < 2; c++) begin
            m_axis_tready = 1'b0;
            #1;
            total++; if (s_axis_tready_2 !== 1'b0) begin bad++; $display("FAIL bp_tready%0d got=%b want=0", c, s_axis_tready_2); end
            step();
            total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA000_0231) begin bad++;
                $display("FAIL bp_hold%0d tvalid/tdata got=%b/%h want=1/a0000231", c, m_axis_tvalid, m_axis_tdata); end
        end
        m_axis_tready = 1'b1;
        step();
        total++; if (m_axis_tdata !== 32'hA000_0232) begin bad++; $display("FAIL bp_resume got=%h want=a0000232", m_axis_tdata); end
        run_until_idle("bp", 20);
        total++; if (outq.size() != expq.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, outq[i], expq[i]); end
        end
    endtask

    task automatic test_gap();
        int n;
        reset_dut();
        for (int b = 0; b < 3; b++) begin
            q0.push_back(mkb(0, 5, b, b == 2));
            expq.push_back(mko(0, 5, b, b == 2));
        end
        for (int b = 0; b < 2; b++) begin
            q1.push_back(mkb(1, 5, b, b == 1));
            expq.push_back(mko(1, 5, b, b == 1));
        end
        drive();
        n = 0;
        while (q0.size() > 2 && n < 10) begin step(); n++; end
        total++; if (q0.size() != 2) begin bad++; $display("FAIL gap_first_beat remaining=%0d want=2", q0.size()); end
        gate[0] = 1'b0;
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (grant !== 2'd0 || busy !== 1'b1 || s_axis_tready_1 !== 1'b0) begin bad++;
                $display("FAIL gap_hold%0d grant/busy/tready1 got=%0d/%b/%b want=0/1/0", c, grant, busy, s_axis_tready_1); end
        end
        total++; if (q1.size() != 2) begin bad++; $display("FAIL gap_src1_waiting remaining=%0d want=2", q1.size()); end
        gate[0] = 1'b1;
        drive();
        run_until_idle("gap", 40);
        total++; if (outq.size() != expq.size()) begin bad++; $display("FAIL gap_count got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin bad++; $display("FAIL gap_beat%0d got=%h want=%h", i, outq[i], expq[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        reset_dut();
        for (int b = 0; b < 4; b++) q1.push_back(mkb(1, 7, b, b == 3));
        drive();
        n = 0;
        while (!(m_axis_tvalid === 1'b1 && m_axis_tdata === 32'hA000_0171) && n < 10) begin step(); n++; end
        total++; if (m_axis_tdata !== 32'hA000_0171) begin bad++; $display("FAIL rmid_reach_b2 got=%h want=a0000171", m_axis_tdata); end
        rst_n = 1'b0;
        #1;
        total++; if (m_axis_tvalid !== 1'b0 || grant !== 2'd2 || busy !== 1'b0) begin bad++;
            $display("FAIL rmid_async tvalid/grant/busy got=%b/%0d/%b want=0/2/0", m_axis_tvalid, grant, busy); end
        outq.delete(); expq.delete();
        for (int b = 0; b < 2; b++) begin
            q0.push_back(mkb(0, 8, b, b == 1));
            expq.push_back(mko(0, 8, b, b == 1));
        end
        // Remaining upstream beats form a new packet after the reset.
        expq.push_back(mko(1, 7, 2, 1'b0));
        expq.push_back(mko(1, 7, 3, 1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        drive();
        step();
        total++; if (grant !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL rmid_regrant grant/busy got=%0d/%b want=0/1", grant, busy); end
        run_until_idle("rmid", 40);
        total++; if (outq.size() != expq.size()) begin bad++; $display("FAIL rmid_count got=%0d want=%0d", outq.size(), expq.size()); end
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin bad++; $display("FAIL rmid_beat%0d got=%h want=%h", i, outq[i], expq[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        gate = 3'b111;
        m_axis_tready = 1'b1;
        drive();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
